sync_sig_debounce: RTL and testbench

//   Glitch filter and edge detector placed directly downstream of the 2-FF signal synchronizer.

---
 rtl/sync_sig_debounce.sv | 135 +++++++++++++
 tb/tb_sync_sig_debounce.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_sig_debounce.sv
// Glitch filter and edge detector for an already-synchronized 1-bit level.
// Optional rising-edge event counter enabled by defining SYNCSIG_EDGE_COUNT_EN.
module sync_sig_debounce #(
  parameter int   STABLE_CC  = 4,
  parameter logic INIT_LEVEL = 1'b0,
  parameter int   CNT_BITS   = 16
) (
  input  logic                piul1Clock,
  input  logic                piul1Reset,
  input  logic                piul1SigIn,
  input  logic                piul1Enable,
  input  logic                piul1CountClear,
  output logic                poul1Level,
  output logic                poul1Rise,
  output logic                poul1Fall,
  output logic                poul1Busy,
  output logic [CNT_BITS-1:0] pouvEdgeCount
);

  localparam int CW = $clog2(STABLE_CC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CC - 1);

  if (STABLE_CC < 1) begin : g_bad_stable_cc
    $error("sync_sig_debounce: STABLE_CC must be >= 1");
  end

  typedef enum logic {
    ST_STABLE,
    ST_CANDIDATE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          commit;

  // NOTE: every variable gets a default first so no path leaves it unassigned
  // (which would infer a latch); blocking '=' is correct inside always_comb.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;

    if (!piul1Enable) begin
      // Disabled: any in-progress candidate is abandoned, level frozen.
      state_d = ST_STABLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_STABLE: begin
          if (piul1SigIn != level_q) begin
            if (STABLE_CC == 1) begin
              commit = 1'b1;
            end else begin
              state_d = ST_CANDIDATE;
              cnt_d   = CW'(1);
            end
          end
        end
        ST_CANDIDATE: begin
          if (piul1SigIn == level_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            commit = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (commit) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      fall_d  = level_q;
      state_d = ST_STABLE;
      cnt_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from values sampled at the same edge.
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign poul1Level = level_q;
  assign poul1Rise  = rise_q;
  assign poul1Fall  = fall_q;
  assign poul1Busy  = (state_q == ST_CANDIDATE);

`ifdef SYNCSIG_EDGE_COUNT_EN
  logic [CNT_BITS-1:0] edge_cnt_q;

  // Clear wins over a coincident rise; the edge is then not counted.
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      edge_cnt_q <= '0;
    end else if (piul1CountClear) begin
      edge_cnt_q <= '0;
    end else if (rise_d) begin
      edge_cnt_q <= edge_cnt_q + CNT_BITS'(1);
    end
  end

  assign pouvEdgeCount = edge_cnt_q;
`else
  logic unused_count_clear;
  assign unused_count_clear = piul1CountClear;
  assign pouvEdgeCount      = '0;
`endif

endmodule

// File: tb/tb_sync_sig_debounce.sv
// Bench for sync_sig_debounce: directed table, corner sequences and random
// stimulus against a run-length reference model (two configurations).
module tb_sync_sig_debounce;

  logic clk;
  logic rst, en, sig, clr;

  logic        main_level, main_rise, main_fall, main_busy;
  logic [1:0]  main_count;
  logic        fast_level, fast_rise, fast_fall, fast_busy;
  logic [15:0] fast_count;

  int n_tests = 0;
  int n_fail  = 0;

  sync_sig_debounce #(.STABLE_CC(4), .INIT_LEVEL(1'b0), .CNT_BITS(2)) u_main (
    .piul1Clock     (clk),
    .piul1Reset     (rst),
    .piul1SigIn     (sig),
    .piul1Enable    (en),
    .piul1CountClear(clr),
    .poul1Level     (main_level),
    .poul1Rise      (main_rise),
    .poul1Fall      (main_fall),
    .poul1Busy      (main_busy),
    .pouvEdgeCount  (main_count)
  );

  sync_sig_debounce #(.STABLE_CC(1), .INIT_LEVEL(1'b1), .CNT_BITS(16)) u_fast (
    .piul1Clock     (clk),
    .piul1Reset     (rst),
    .piul1SigIn     (sig),
    .piul1Enable    (en),
    .piul1CountClear(clr),
    .poul1Level     (fast_level),
    .poul1Rise      (fast_rise),
    .poul1Fall      (fast_fall),
    .poul1Busy      (fast_busy),
    .pouvEdgeCount  (fast_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts consecutive enabled cycles where the input
  // differs from the published level; accepts the change after cc of them.
  int   m_cc[2]   = '{4, 1};
  logic m_init[2] = '{1'b0, 1'b1};
  int   m_mod[2]  = '{4, 65536};
  logic m_level[2];
  int   m_run[2];
  logic m_rise[2];
  logic m_fall[2];
  int   m_cnt[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic lv, ri, fa;
      int   run, cnt;
      lv = m_level[i]; run = m_run[i]; cnt = m_cnt[i];
      ri = 1'b0; fa = 1'b0;
      if (rst) begin
        lv = m_init[i]; run = 0; cnt = 0;
      end else begin
        if (en && (sig != lv)) begin
          run = run + 1;
          if (run == m_cc[i]) begin
            ri = sig; fa = ~sig; lv = sig; run = 0;
          end
        end else begin
          run = 0;
        end
        if (clr) cnt = 0;
        else if (ri) cnt = (cnt + 1) % m_mod[i];
      end
      m_level[i] <= lv;
      m_run[i]   <= run;
      m_rise[i]  <= ri;
      m_fall[i]  <= fa;
      m_cnt[i]   <= cnt;
    end
  end

  function automatic int exp_count(input int i);
`ifdef SYNCSIG_EDGE_COUNT_EN
    return m_cnt[i];
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_all();
    check("main_level", main_level, m_level[0]);
    check("main_rise",  main_rise,  m_rise[0]);
    check("main_fall",  main_fall,  m_fall[0]);
    check("main_busy",  main_busy,  m_run[0] != 0);
    check("main_count", main_count, exp_count(0));
    check("fast_level", fast_level, m_level[1]);
    check("fast_rise",  fast_rise,  m_rise[1]);
    check("fast_fall",  fast_fall,  m_fall[1]);
    check("fast_busy",  fast_busy,  m_run[1] != 0);
    check("fast_count", fast_count, exp_count(1));
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next one.
  task automatic step(input logic r, input logic e, input logic s, input logic c);
    rst = r; en = e; sig = s; clr = c;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    logic rst, en, sig, clr;
    logic level, rise, fall, busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, e, s, c, l, ri, f, b);
    vec_t v;
    v.rst = r; v.en = e; v.sig = s; v.clr = c;
    v.level = l; v.rise = ri; v.fall = f; v.busy = b;
    vecs.push_back(v);
  endtask

  initial begin
    int   hold;
    logic s;
    logic [31:0] exp_c;

    rst = 1'b1; en = 1'b1; sig = 1'b0; clr = 1'b0;
    @(negedge clk);

    // T1: two reset cycles with input 0; INIT_LEVEL=1 instance must read 1.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("t1_fast_level", fast_level, 1);
    check("t1_fast_rise",  fast_rise,  0);
    check("t1_fast_fall",  fast_fall,  0);
    check("t1_fast_busy",  fast_busy,  0);
    check("t1_fast_count", fast_count, 0);
    check("t1_main_level", main_level, 0);

    // Directed table for the STABLE_CC=4, INIT_LEVEL=0 instance.
    //   rst en sig clr | level rise fall busy
    add(1, 1, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0,  0, 0, 0, 0);
    // glitch: high for three edges then low
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 0, 0,  0, 0, 0, 0);
    // clean rise: committed on the fourth edge
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  1, 1, 0, 0);
    add(0, 1, 1, 0,  1, 0, 0, 0);
    // clean fall
    add(0, 1, 0, 0,  1, 0, 0, 1);
    add(0, 1, 0, 0,  1, 0, 0, 1);
    add(0, 1, 0, 0,  1, 0, 0, 1);
    add(0, 1, 0, 0,  0, 0, 1, 0);
    add(0, 1, 0, 0,  0, 0, 0, 0);
    // enable dropped after two candidate edges, restored one cycle later
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 0, 1, 0,  0, 0, 0, 0);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  1, 1, 0, 0);
    add(0, 1, 1, 0,  1, 0, 0, 0);
    // reset on second candidate edge, then held input re-qualifies
    add(0, 1, 0, 0,  1, 0, 0, 1);
    add(1, 1, 1, 0,  0, 0, 0, 0);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 1, 0,  1, 1, 0, 0);
    // toggling every cycle never commits
    add(0, 1, 0, 0,  1, 0, 0, 1);
    add(0, 1, 1, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0,  1, 0, 0, 1);
    add(0, 1, 1, 0,  1, 0, 0, 0);
    add(0, 1, 0, 0,  1, 0, 0, 1);
    add(0, 1, 1, 0,  1, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].sig, vecs[i].clr);
      check($sformatf("tbl%0d_level", i), main_level, vecs[i].level);
      check($sformatf("tbl%0d_rise",  i), main_rise,  vecs[i].rise);
      check($sformatf("tbl%0d_fall",  i), main_fall,  vecs[i].fall);
      check($sformatf("tbl%0d_busy",  i), main_busy,  vecs[i].busy);
    end

    // T6: edge counter on a 2-bit counter; clear coincides with the 6th rise.
    step(1, 1, 0, 0);
    for (int p = 0; p < 6; p++) begin
      for (int j = 0; j < 4; j++) step(0, 1, 1, (p == 5 && j == 3));
      check($sformatf("t6_rise%0d", p), main_rise, 1);
`ifdef SYNCSIG_EDGE_COUNT_EN
      exp_c = (p < 5) ? 32'((p + 1) % 4) : 32'd0;
`else
      exp_c = 32'd0;
`endif
      check($sformatf("t6_count%0d", p), main_count, exp_c);
      for (int j = 0; j < 5; j++) step(0, 1, 0, 0);
    end

    // Random stimulus: runs of 1..7 cycles with occasional disable/reset/clear.
    hold = 0;
    s = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        s = ~s;
        hold = $urandom_range(0, 6);
      end else begin
        hold--;
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0, s,
           $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
